// File: rtl/ibf_pkg.sv
// Shared defaults, complex-word types and the b-output range reduction for the inverse butterfly.
// Defining IBF_SAT_EN makes sat_or_wrap clamp; otherwise it wraps (two's complement).
package ibf_pkg;

  localparam int unsigned IbfDw     = 16;
  localparam int unsigned IbfTwFrac = 15;

  typedef struct packed {
    logic signed [IbfDw-1:0] re;
    logic signed [IbfDw-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [IbfDw:0] re;
    logic signed [IbfDw:0] im;
  } cplx_wide_t;

  // Reduce a sign-extended value to dw bits; the result is sign-extended back to 64 bits.
  function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] v,
                                                     input int unsigned       dw);
    logic signed [63:0] r;
`ifdef IBF_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = ~hi;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
`else
    r = (v <<< (64 - dw)) >>> (64 - dw);
`endif
    return r;
  endfunction

endpackage

// File: rtl/ibf_cmul_conj.sv
// Registered conjugate-twiddle multiply: pr = dr*wr + di*wi, pi = di*wr - dr*wi.
// wi is only ever used through the sign of its terms, so a -2^(DW-1) twiddle cannot overflow.
module ibf_cmul_conj
  import ibf_pkg::*;
#(
  parameter int unsigned DW = IbfDw
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic signed [DW:0]    dr_i,
  input  logic signed [DW:0]    di_i,
  input  logic [2*DW-1:0]       w_i,
  output logic signed [2*DW+1:0] pr_o,
  output logic signed [2*DW+1:0] pi_o
);

  localparam int unsigned PW = 2*DW + 2;

  logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x;
  logic signed [PW-1:0] m_rr, m_ii, m_ir, m_ri;
  logic signed [PW-1:0] pr_d, pi_d;

  assign dr_x = {{(DW+1){dr_i[DW]}}, dr_i};
  assign di_x = {{(DW+1){di_i[DW]}}, di_i};
  assign wr_x = {{(DW+2){w_i[2*DW-1]}}, w_i[2*DW-1:DW]};
  assign wi_x = {{(DW+2){w_i[DW-1]}}, w_i[DW-1:0]};

  always_comb begin
    m_rr = dr_x * wr_x;
    m_ii = di_x * wi_x;
    m_ir = di_x * wr_x;
    m_ri = dr_x * wi_x;
    pr_d = m_rr + m_ii;
    pi_d = m_ir - m_ri;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pr_o <= '0;
      pi_o <= '0;
    end else if (en_i) begin
      pr_o <= pr_d;
      pi_o <= pi_d;
    end
  end

endmodule

// File: rtl/ibutterfly_pipe.sv
// Three-stage inverse radix-2 butterfly: a = (x0+x1)/2, b = conj(w)*(x0-x1)/2, valid/ready.
// Build with IBF_SAT_EN to clamp b components instead of wrapping them.
module ibutterfly_pipe
  import ibf_pkg::*;
#(
  parameter int unsigned DW      = IbfDw,
  parameter int unsigned TW_FRAC = IbfTwFrac
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] x0,
  input  logic [2*DW-1:0] x1,
  input  logic [2*DW-1:0] w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] a,
  output logic [2*DW-1:0] b
);

  localparam int unsigned PW = 2*DW + 2;

  logic adv;

  logic signed [DW:0]   x0r, x0i, x1r, x1i;
  logic                 v1_q;
  logic signed [DW:0]   sr_q, si_q, dr_q, di_q;
  logic [2*DW-1:0]      w1_q;

  logic                 v2_q;
  logic signed [DW:0]   sr2_q, si2_q;
  logic signed [PW-1:0] pr_q, pi_q;

  logic                 v3_q;
  logic [2*DW-1:0]      a_q, b_q;
  logic [DW-1:0]        are_d, aim_d, bre_d, bim_d;
  logic signed [PW-1:0] br_sh, bi_sh;

  // The whole pipe moves as one; bubbles are kept rather than squeezed out.
  assign adv       = out_ready || !v3_q;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign a         = a_q;
  assign b         = b_q;

  assign x0r = {x0[2*DW-1], x0[2*DW-1:DW]};
  assign x0i = {x0[DW-1], x0[DW-1:0]};
  assign x1r = {x1[2*DW-1], x1[2*DW-1:DW]};
  assign x1i = {x1[DW-1], x1[DW-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      sr_q <= '0;
      si_q <= '0;
      dr_q <= '0;
      di_q <= '0;
      w1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      sr_q <= x0r + x1r;
      si_q <= x0i + x1i;
      dr_q <= x0r - x1r;
      di_q <= x0i - x1i;
      w1_q <= w;
    end
  end

  ibf_cmul_conj #(
    .DW(DW)
  ) u_cmul (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (adv),
    .dr_i   (dr_q),
    .di_i   (di_q),
    .w_i    (w1_q),
    .pr_o   (pr_q),
    .pi_o   (pi_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      sr2_q <= '0;
      si2_q <= '0;
    end else if (adv) begin
      v2_q  <= v1_q;
      sr2_q <= sr_q;
      si2_q <= si_q;
    end
  end

  // Halving a DW+1 sum always fits DW bits; b needs range reduction.
  always_comb begin
    are_d = DW'(sr2_q >>> 1);
    aim_d = DW'(si2_q >>> 1);
    br_sh = pr_q >>> (TW_FRAC + 1);
    bi_sh = pi_q >>> (TW_FRAC + 1);
    bre_d = DW'(sat_or_wrap(64'(br_sh), DW));
    bim_d = DW'(sat_or_wrap(64'(bi_sh), DW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      a_q  <= {are_d, aim_d};
      b_q  <= {bre_d, bim_d};
    end
  end

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Scoreboard bench for ibutterfly_pipe: arithmetic reference model, random traffic and stalls.
module tb_ibutterfly_pipe;
  import ibf_pkg::*;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x0, x1, w, a, b;

  ibutterfly_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b)
  );

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    bit          rt;
    logic [31:0] ra;
    logic [31:0] rb;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          stall_cnt = 0;
  int          ov_cnt = 0;
  bit          bp_rand = 0;
  bit          stall_en = 0;
  int          stall_lo = 0;
  int          stall_hi = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_a, prev_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint re_of(input logic [31:0] v);
    cplx_t c;
    c = v;
    return longint'(c.re);
  endfunction

  function automatic longint im_of(input logic [31:0] v);
    cplx_t c;
    c = v;
    return longint'(c.im);
  endfunction

  function automatic logic [31:0] pack(input longint re, input longint im);
    cplx_t c;
    c.re = re[15:0];
    c.im = im[15:0];
    return c;
  endfunction

  // pack() keeps the low 16 bits, which is the wrap behaviour.
  function automatic longint fit_b(input longint v);
`ifdef IBF_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  function automatic void model(input logic [31:0] vx0, vx1, vw,
                                output logic [31:0] ea, eb);
    longint dr, di, wr, wi, scale;
    scale = longint'(1) << (IbfTwFrac + 1);
    dr = re_of(vx0) - re_of(vx1);
    di = im_of(vx0) - im_of(vx1);
    wr = re_of(vw);
    wi = im_of(vw);
    ea = pack(fdiv(re_of(vx0) + re_of(vx1), 2), fdiv(im_of(vx0) + im_of(vx1), 2));
    eb = pack(fit_b(fdiv(dr * wr + di * wi, scale)), fit_b(fdiv(di * wr - dr * wi, scale)));
  endfunction

  // Forward butterfly in Q1.15: x0 = a + w*b, x1 = a - w*b.
  function automatic void fwd(input logic [31:0] va, vb, vw, output logic [31:0] vx0, vx1);
    longint wbr, wbi;
    wbr = fdiv(re_of(vb) * re_of(vw) - im_of(vb) * im_of(vw), 32768);
    wbi = fdiv(re_of(vb) * im_of(vw) + im_of(vb) * re_of(vw), 32768);
    vx0 = pack(re_of(va) + wbr, im_of(va) + wbi);
    vx1 = pack(re_of(va) - wbr, im_of(va) - wbi);
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [15:0] r, i;
    r = 16'($urandom);
    i = 16'($urandom);
    if ($urandom_range(7) == 0) r = 16'h8000;
    if ($urandom_range(7) == 0) i = 16'h8000;
    return {r, i};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // The 0x7FFF twiddle is 1-2^-15, applied forward and back with a floor each way.
  task automatic rt_chk(input string name, input longint got, input longint want);
    total++;
    if (got - want > 2 || want - got > 2) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/-2", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      chk("in_ready_eq", {31'b0, in_ready}, {31'b0, out_ready || !out_valid});
      if (!in_ready) stall_cnt++;
      if (out_valid) ov_cnt++;
      if (prev_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_a", a, prev_a);
        chk("hold_b", b, prev_b);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got a=0x%08h b=0x%08h expected no output", a, b);
        end else begin
          mon_e = sb.pop_front();
          chk("a", a, mon_e.ea);
          chk("b", b, mon_e.eb);
          n_out++;
          if (mon_e.rt) begin
            rt_chk("rt_a_re", re_of(a), re_of(mon_e.ra));
            rt_chk("rt_a_im", im_of(a), im_of(mon_e.ra));
            rt_chk("rt_b_re", re_of(b), re_of(mon_e.rb));
            rt_chk("rt_b_im", im_of(b), im_of(mon_e.rb));
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_a    = a;
      prev_b    = b;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(3) != 0);
      else if (stall_en && cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else out_ready = 1'b1;
    end
  end

  task automatic send(input logic [31:0] vx0, vx1, vw, input bit rt,
                      input logic [31:0] ra, rb);
    exp_t e;
    int   g;
    in_valid = 1'b1;
    x0 = vx0;
    x1 = vx1;
    w  = vw;
    g  = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 200);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      model(vx0, vx1, vw, e.ea, e.eb);
      e.rt = rt;
      e.ra = ra;
      e.rb = rb;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    in_valid = 1'b0;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int          n, n0, ov0;
    logic [31:0] rx0, rx1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x0 = '0;
    x1 = '0;
    w  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Identity twiddle, with latency counted from the accepting edge.
    send(32'h0100_0200, 32'h0040_0080, 32'h7FFF_0000, 1'b0, '0, '0);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", n, 32'd3);
    chk("ident_a", a, 32'h00A0_0140);
    chk("ident_b", b, 32'h005F_00BF);
    drain();

    send(32'h0100_0200, 32'h0040_0080, 32'h0000_8000, 1'b0, '0, '0);
    send(32'h7FFF_7FFF, 32'h8000_8000, 32'h7FFF_7FFF, 1'b0, '0, '0);
    send(32'h1234_ABCD, 32'h8000_7FFF, 32'h0000_0000, 1'b0, '0, '0);
    send(32'h8000_8000, 32'h7FFF_8000, 32'h8000_8000, 1'b0, '0, '0);
    fwd(32'h1234_0001, 32'h4321_0000, 32'h7FFF_0000, rx0, rx1);
    send(rx0, rx1, 32'h7FFF_0000, 1'b1, 32'h1234_0001, 32'h4321_0000);
    drain();

    // Five back-to-back items with out_ready low for four cycles.
    stall_lo  = cyc + 4;
    stall_hi  = cyc + 7;
    stall_en  = 1'b1;
    stall_cnt = 0;
    n0        = n_out;
    for (int i = 0; i < 5; i++) send(rnd_word(), rnd_word(), rnd_word(), 1'b0, '0, '0);
    drain();
    stall_en = 1'b0;
    chk("bp_stall_cycles", stall_cnt, 32'd4);
    chk("bp_delivered", n_out - n0, 32'd5);

    // Reset with two items in flight.
    send(rnd_word(), rnd_word(), rnd_word(), 1'b0, '0, '0);
    send(rnd_word(), rnd_word(), rnd_word(), 1'b0, '0, '0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_a", a, 32'd0);
    chk("midrst_b", b, 32'd0);
    sb.delete();
    ov0 = ov_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_stale", ov_cnt - ov0, 32'd0);

    // Random traffic with random backpressure and input gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rnd_word(), rnd_word(), rnd_word(), 1'b0, '0, '0);
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
    end
    drain();
    bp_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
